fir_tap_accumulator: RTL and testbench
======================================

// Module: fir_tap_accumulator
// PURPOSE
//   Downstream of the 16s x 9u coefficient multiplier in each filterbank branch.
//   Sums the signed 25-bit tap products of one polyphase output sample over NUM_TAPS beats.
//   Rounds and saturates each sum to a 16-bit output sample.
//   Presents the result on a valid/ready stream to the next rate-change stage.
// PARAMETERS
//   NUM_TAPS  16  products per output sample (>=2)
//   PROD_W    25  product width, signed
//   ACC_W     32  accumulator width; must be >= PROD_W + clog2(NUM_TAPS), so no internal wrap
//   OUT_W     16  output sample width, signed
//   SHIFT      8  fractional bits dropped at output (>=1)
// PORTS
//   ap_clk       in   1         clock, rising edge
//   ap_rst       in   1         synchronous reset, active-high
//   prod_tdata   in   PROD_W    signed product from multiplier
//   prod_tvalid  in   1         product valid
//   prod_tready  out  1         product accepted when tvalid & tready
//   prod_tlast   in   1         upstream marks last tap of a sample
//   out_tdata    out  OUT_W     rounded/saturated signed sample
//   out_tvalid   out  1         output register holds a sample
//   out_tready   in   1         downstream accepts when tvalid & tready
//   sat_sticky   out  1         set when any output saturated; cleared only by reset
//   frame_err    out  1         set on tlast/counter mismatch; cleared only by reset
// BEHAVIOUR
//   Reset (ap_rst=1 at a rising edge): acc=0, tap_cnt=0, out_tdata=0, out_tvalid=0,
//     sat_sticky=0, frame_err=0. Reset mid-sample discards the partial sum and any held output.
//   Beat: prod_tvalid & prod_tready. Signals are sampled at rising edge.
//   prod_tready = ~(out_tvalid & ~out_tready). Combinational.
//     Input stalls only while a held output is not being drained.
//   Beat with tap_cnt < NUM_TAPS-1: acc <= acc + sext(prod_tdata); tap_cnt++.
//   Beat with tap_cnt == NUM_TAPS-1 (last tap):
//     sum = acc + sext(prod_tdata)
//     r = (sum + 2^(SHIFT-1)) >>> SHIFT  (round half toward +inf; arithmetic shift)
//     out_tdata <= clamp(r, -2^(OUT_W-1), 2^(OUT_W-1)-1); out_tvalid <= 1
//     acc <= 0; tap_cnt <= 0
//     if the clamp was active: sat_sticky <= 1
//   Latency: last-tap beat at edge N gives out_tvalid=1 after edge N (visible in cycle N+1).
//   Throughput: one sample per NUM_TAPS beats. No bubbles while out_tready=1.
//   Output register: out_tvalid clears on an out_tvalid & out_tready edge,
//     unless a new last-tap beat loads it in the same edge (load wins, stays 1).
//   Framing is owned by tap_cnt. prod_tlast is only checked:
//     frame_err <= 1 if tlast=1 on a beat with tap_cnt != NUM_TAPS-1
//     frame_err <= 1 if tlast=0 on a beat with tap_cnt == NUM_TAPS-1
//     A mismatch never resynchronises tap_cnt.
//   States (implicit in tap_cnt/out_tvalid):
//     ACCUM: out_tvalid=0 or draining.
//     HOLD: out_tvalid=1 & out_tready=0, prod_tready=0; partial acc is frozen.
//   No beat during HOLD. A beat with prod_tvalid=0 changes nothing.
// TESTING (NUM_TAPS=4, SHIFT=8, out_tready=1 unless stated)
//   Products 256,256,256,256, tlast on 4th -> out_tdata=4, one cycle after 4th beat, flags 0.
//   Rounding: sums 128, -128, -129 (e.g. 128,0,0,0 / -128,0,0,0 / -129,0,0,0) -> 1, 0, -1.
//   Saturation, positive: 4x 8388607 -> 32767, sat_sticky=1.
//   Saturation, negative: 4x -8388608 -> -32768.
//   Back-pressure: out_tready=0 after sample 1 -> prod_tready=0, out_tdata held.
//     Release out_tready -> sample 2 exact, no lost or duplicated beats.
//   tlast on 3rd beat -> frame_err=1, output still emitted after 4th beat.
//   ap_rst pulsed after 2 beats -> all outputs 0; next 4 beats give the clean result.

Source files
------------

// File: rtl/fir_tap_accumulator.sv
// fir_tap_accumulator: sums NUM_TAPS signed tap products per polyphase sample, then rounds and saturates to OUT_W.
// Latency: the result is registered on the last-tap beat and is visible the cycle after.
// Backpressure: prod_tready drops only while a held sample is not being drained; the partial sum is frozen meanwhile.
module fir_tap_accumulator #(
   parameter int NUM_TAPS = 16,
   parameter int PROD_W   = 25,
   parameter int ACC_W    = 32,
   parameter int OUT_W    = 16,
   parameter int SHIFT    = 8
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic [PROD_W-1:0] prod_tdata,
   input  logic              prod_tvalid,
   output logic              prod_tready,
   input  logic              prod_tlast,
   output logic [OUT_W-1:0]  out_tdata,
   output logic              out_tvalid,
   input  logic              out_tready,
   output logic              sat_sticky,
   output logic              frame_err
);

   // Tap counter just wide enough to count 0 .. NUM_TAPS-1.
   localparam int CNT_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
   localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

   // Rounding and clamp arithmetic is one bit wider than the accumulator,
   // so adding the half-LSB constant to a full-scale sum cannot wrap.
   localparam logic signed [ACC_W:0] ROUND_K = ({{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1));
   localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

   logic signed [ACC_W-1:0] acc;
   logic        [CNT_W-1:0] tap_cnt;

   logic                    beat;
   logic                    last_tap;
   logic                    load_out;
   logic                    drain_out;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W:0]   rnd;
   logic signed [ACC_W:0]   shifted;
   logic                    clip_hi;
   logic                    clip_lo;
   logic        [OUT_W-1:0] clamped;

   // Input is only stalled while a held sample is waiting on downstream.
   assign prod_tready = ~(out_tvalid & ~out_tready);
   assign beat        = prod_tvalid & prod_tready;
   assign last_tap    = (tap_cnt == LAST_TAP);
   assign load_out    = beat & last_tap;
   assign drain_out   = out_tvalid & out_tready;

   // Datapath: extend product, form the running sum, round half toward +inf, then clamp.
   always_comb begin
      prod_ext = {{(ACC_W - PROD_W){prod_tdata[PROD_W-1]}}, prod_tdata};
      sum      = acc + prod_ext;
      rnd      = $signed({sum[ACC_W-1], sum}) + ROUND_K;
      shifted  = rnd >>> SHIFT;
      clip_hi  = (shifted > OUT_MAX);
      clip_lo  = (shifted < OUT_MIN);
      clamped  = shifted[OUT_W-1:0];
      if (clip_hi) begin
         clamped = OUT_MAX[OUT_W-1:0];
      end else if (clip_lo) begin
         clamped = OUT_MIN[OUT_W-1:0];
      end
   end

   // Accumulator and tap counter: framing is owned here, tlast never resynchronises it.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         acc     <= '0;
         tap_cnt <= '0;
      end else if (beat) begin
         if (last_tap) begin
            acc     <= '0;
            tap_cnt <= '0;
         end else begin
            acc     <= sum;
            tap_cnt <= tap_cnt + 1'b1;
         end
      end
   end

   // Output register: a new sample load wins over a simultaneous drain.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         out_tdata  <= '0;
         out_tvalid <= 1'b0;
      end else if (load_out) begin
         out_tdata  <= clamped;
         out_tvalid <= 1'b1;
      end else if (drain_out) begin
         out_tvalid <= 1'b0;
      end
   end

   // Sticky status flags, cleared only by reset.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         sat_sticky <= 1'b0;
         frame_err  <= 1'b0;
      end else if (beat) begin
         if (last_tap && (clip_hi || clip_lo)) begin
            sat_sticky <= 1'b1;
         end
         if (prod_tlast != last_tap) begin
            frame_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Testbench for fir_tap_accumulator (NUM_TAPS=4, SHIFT=8).
// Directed cases followed by randomized traffic, all checked against a queue-based sample model.
module tb_fir_tap_accumulator;

   localparam int NT = 4;
   localparam int PW = 25;
   localparam int AW = 32;
   localparam int OW = 16;
   localparam int SH = 8;

   logic          ap_clk = 1'b0;
   logic          ap_rst;
   logic [PW-1:0] prod_tdata;
   logic          prod_tvalid;
   logic          prod_tready;
   logic          prod_tlast;
   logic [OW-1:0] out_tdata;
   logic          out_tvalid;
   logic          out_tready;
   logic          sat_sticky;
   logic          frame_err;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: products of the sample in progress, plus the visible output state.
   longint        m_prods[$];
   logic          m_valid = 1'b0;
   logic [OW-1:0] m_data  = '0;
   logic          m_sat   = 1'b0;
   logic          m_err   = 1'b0;

   fir_tap_accumulator #(
      .NUM_TAPS(NT), .PROD_W(PW), .ACC_W(AW), .OUT_W(OW), .SHIFT(SH)
   ) dut (
      .ap_clk(ap_clk),
      .ap_rst(ap_rst),
      .prod_tdata(prod_tdata),
      .prod_tvalid(prod_tvalid),
      .prod_tready(prod_tready),
      .prod_tlast(prod_tlast),
      .out_tdata(out_tdata),
      .out_tvalid(out_tvalid),
      .out_tready(out_tready),
      .sat_sticky(sat_sticky),
      .frame_err(frame_err)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      check("out_tvalid", {31'b0, out_tvalid}, {31'b0, m_valid});
      check("out_tdata",  {16'b0, out_tdata},  {16'b0, m_data});
      check("sat_sticky", {31'b0, sat_sticky}, {31'b0, m_sat});
      check("frame_err",  {31'b0, frame_err},  {31'b0, m_err});
   endtask

   // Apply one rising edge's worth of behaviour to the model.
   task automatic model_edge(input logic rst, input logic v, input longint d,
                             input logic l, input logic r, input logic rdy);
      logic          load;
      longint        s;
      longint        rr;
      logic signed [PW-1:0] ds;
      load = 1'b0;
      ds   = PW'(d);
      if (rst) begin
         m_prods.delete();
         m_valid = 1'b0;
         m_data  = '0;
         m_sat   = 1'b0;
         m_err   = 1'b0;
      end else begin
         if (v && rdy) begin
            m_prods.push_back(longint'(ds));
            if (l != (m_prods.size() == NT)) m_err = 1'b1;
            if (m_prods.size() == NT) begin
               s = 0;
               foreach (m_prods[i]) s += m_prods[i];
               rr = (s + (longint'(1) <<< (SH - 1))) >>> SH;
               if (rr > 32767) begin
                  rr = 32767;
                  m_sat = 1'b1;
               end else if (rr < -32768) begin
                  rr = -32768;
                  m_sat = 1'b1;
               end
               m_data  = OW'(rr);
               m_valid = 1'b1;
               load    = 1'b1;
               m_prods.delete();
            end
         end
         if (!load && m_valid && r) m_valid = 1'b0;
      end
   endtask

   // One clock cycle: drive inputs, check the combinational ready, clock, check registered outputs.
   task automatic cyc(input logic rst, input logic v, input longint d, input logic l, input logic r);
      logic exp_rdy;
      ap_rst      = rst;
      prod_tvalid = v;
      prod_tdata  = PW'(d);
      prod_tlast  = l;
      out_tready  = r;
      #1;
      exp_rdy = !(m_valid && !r);
      check("prod_tready", {31'b0, prod_tready}, {31'b0, exp_rdy});
      @(posedge ap_clk);
      model_edge(rst, v, d, l, r, exp_rdy);
      #1;
      check_outputs();
   endtask

   task automatic send4(input longint a, input longint b, input longint c, input longint d,
                        input int last_at);
      cyc(1'b0, 1'b1, a, last_at == 0, 1'b1);
      cyc(1'b0, 1'b1, b, last_at == 1, 1'b1);
      cyc(1'b0, 1'b1, c, last_at == 2, 1'b1);
      cyc(1'b0, 1'b1, d, last_at == 3, 1'b1);
   endtask

   initial begin
      logic   rv;
      logic   rl;
      logic   rr;
      logic   rrst;
      longint rd;

      // Reset from power-up unknown state.
      ap_rst      = 1'b1;
      prod_tvalid = 1'b0;
      prod_tdata  = '0;
      prod_tlast  = 1'b0;
      out_tready  = 1'b1;
      @(posedge ap_clk);
      model_edge(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1);
      #1;
      check_outputs();
      check("reset_rdy", {31'b0, prod_tready}, 32'd1);

      // Basic sample: 4 x 256 -> 4.
      send4(256, 256, 256, 256, 3);
      check("basic_data", {16'b0, out_tdata}, 32'd4);
      check("basic_valid", {31'b0, out_tvalid}, 32'd1);
      cyc(1'b0, 1'b0, 0, 1'b0, 1'b1);

      // Rounding at the half-LSB boundary.
      send4(128, 0, 0, 0, 3);
      check("round_p128", {16'b0, out_tdata}, 32'h0001);
      send4(-128, 0, 0, 0, 3);
      check("round_m128", {16'b0, out_tdata}, 32'h0000);
      send4(-129, 0, 0, 0, 3);
      check("round_m129", {16'b0, out_tdata}, 32'h0000_FFFF);
      check("round_nosat", {31'b0, sat_sticky}, 32'd0);

      // Saturation at both rails.
      send4(8388607, 8388607, 8388607, 8388607, 3);
      check("sat_pos", {16'b0, out_tdata}, 32'h0000_7FFF);
      check("sat_sticky", {31'b0, sat_sticky}, 32'd1);
      send4(-8388608, -8388608, -8388608, -8388608, 3);
      check("sat_neg", {16'b0, out_tdata}, 32'h0000_8000);

      // Back-pressure: hold sample 1, then release and complete sample 2.
      send4(1000, 2000, 3000, 4000, 3);
      cyc(1'b0, 1'b1, 512, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 512, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 512, 1'b0, 1'b0);
      check("hold_rdy", {31'b0, prod_tready}, 32'd0);
      check("hold_data", {16'b0, out_tdata}, 32'd39);
      check("hold_valid", {31'b0, out_tvalid}, 32'd1);
      cyc(1'b0, 1'b1, 512, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 512, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 512, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 512, 1'b1, 1'b1);
      check("bp_sample2", {16'b0, out_tdata}, 32'd8);
      cyc(1'b0, 1'b0, 0, 1'b0, 1'b1);

      // Misplaced tlast flags an error but framing stays on the counter.
      check("pre_frame_err", {31'b0, frame_err}, 32'd0);
      send4(256, 0, 0, 0, 2);
      check("frame_err", {31'b0, frame_err}, 32'd1);
      check("frame_data", {16'b0, out_tdata}, 32'd1);
      check("frame_valid", {31'b0, out_tvalid}, 32'd1);

      // Reset mid-sample discards the partial sum.
      cyc(1'b0, 1'b1, 300, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 300, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 0, 1'b0, 1'b1);
      check("rst_data", {16'b0, out_tdata}, 32'd0);
      check("rst_flags", {30'b0, sat_sticky, frame_err}, 32'd0);
      send4(512, 512, 512, 512, 3);
      check("post_rst_data", {16'b0, out_tdata}, 32'd8);
      check("post_rst_err", {31'b0, frame_err}, 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         rv   = ($urandom_range(0, 9) < 7);
         rr   = ($urandom_range(0, 9) < 7);
         rrst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 3) == 0) begin
            rd = longint'($signed(PW'($urandom)));
         end else begin
            rd = longint'($urandom_range(0, 8191)) - 4096;
         end
         rl = (m_prods.size() == NT - 1) ^ ($urandom_range(0, 39) == 0);
         cyc(rrst, rv, rd, rl, rr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
